// File: rtl/cmp_serial_unit.sv
// Chunk-serial magnitude comparator: scans CHUNK bits per cycle MSB-first,
// terminates on the first differing chunk, supports unsigned and signed modes.
module cmp_serial_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  localparam int unsigned NCHUNK = WIDTH / CHUNK,
  localparam int unsigned CW = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             signed_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [CW-1:0]    chunks_used
);

  localparam int unsigned IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $fatal(1, "cmp_serial_unit: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     used_q, used_d;
  logic              lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
  logic [WIDTH-1:0]  bias;
  logic [CHUNK-1:0]  a_chunk, b_chunk;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the scan itself is always unsigned.
  assign bias    = signed_mode ? (WIDTH'(1) << (WIDTH - 1)) : '0;
  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  // Next-state and result logic for the accept/scan/hold sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    used_d  = used_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = op_a ^ bias;
          b_d     = op_b ^ bias;
          idx_d   = IW'(NCHUNK - 1);
          cnt_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        cnt_d = cnt_q + CW'(1);
        if (a_chunk != b_chunk) begin
          lt_d    = (a_chunk < b_chunk);
          gt_d    = (a_chunk > b_chunk);
          eq_d    = 1'b0;
          used_d  = cnt_q + CW'(1);
          state_d = StDone;
        end else if (idx_q == '0) begin
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          used_d  = CW'(NCHUNK);
          state_d = StDone;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      used_q  <= '0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      used_q  <= used_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  // All outputs come straight from registers.
  assign start_ready = (state_q == StIdle);
  assign res_valid   = (state_q == StDone);
  assign lt          = lt_q;
  assign gt          = gt_q;
  assign eq          = eq_q;
  assign chunks_used = used_q;

endmodule

// File: tb/tb_cmp_serial_unit.sv
// Self-checking bench for cmp_serial_unit: 16/4 and 32/8 instances, directed
// cases plus randomized operations against a behavioural reference.
module tb_cmp_serial_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit / 4-bit-chunk instance
  logic        sv16 = 1'b0, rr16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        srdy16, rv16, lt16, gt16, eq16;
  logic [2:0]  used16;

  // 32-bit / 8-bit-chunk instance
  logic        sv32 = 1'b0, rr32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        srdy32, rv32, lt32, gt32, eq32;
  logic [2:0]  used32;

  int passed = 0;
  int total  = 0;

  cmp_serial_unit #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv16), .start_ready(srdy16),
    .op_a(a16), .op_b(b16), .signed_mode(sm16), .res_valid(rv16),
    .res_ready(rr16), .lt(lt16), .gt(gt16), .eq(eq16), .chunks_used(used16)
  );

  cmp_serial_unit #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv32), .start_ready(srdy32),
    .op_a(a32), .op_b(b32), .signed_mode(sm32), .res_valid(rv32),
    .res_ready(rr32), .lt(lt32), .gt(gt32), .eq(eq32), .chunks_used(used32)
  );

  // Reference: chunks examined = position (from the top) of the first
  // non-zero chunk of a^b; the sign bias never changes a^b.
  function automatic int ref_used(input logic [31:0] a, input logic [31:0] b,
                                  input int w, input int c);
    logic [31:0] x;
    logic [31:0] ch;
    x = a ^ b;
    for (int k = 0; k < w / c; k++) begin
      ch = (x >> (w - (k + 1) * c)) & ((32'd1 << c) - 32'd1);
      if (ch != 0) return k + 1;
    end
    return w / c;
  endfunction

  // Reference ordering: -1 less, 0 equal, +1 greater, using plain integers.
  function automatic int ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                 input int w, input bit sm);
    longint va, vb;
    va = longint'(a);
    vb = longint'(b);
    if (sm && a[w-1]) va = va - (longint'(1) << w);
    if (sm && b[w-1]) vb = vb - (longint'(1) << w);
    if (va < vb) return -1;
    if (va > vb) return 1;
    return 0;
  endfunction

  function automatic logic [2:0] flags_of(input int r);
    return {r < 0, r > 0, r == 0};
  endfunction

  // Issue one operation, count edges to res_valid, capture flags, then take it.
  task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                        input bit sm, output int lat, output logic [2:0] flg,
                        output logic [2:0] used);
    @(negedge clk);
    if (wide) begin a32 = a; b32 = b; sm32 = sm; sv32 = 1'b1; end
    else begin a16 = a[15:0]; b16 = b[15:0]; sm16 = sm; sv16 = 1'b1; end
    @(posedge clk);
    #1;
    // Scramble operands after the accepting edge; they must not matter.
    if (wide) begin sv32 = 1'b0; a32 = $urandom; b32 = $urandom; sm32 = ~sm; end
    else begin sv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sm16 = ~sm; end
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!(wide ? rv32 : rv16) && lat < 40);
    flg  = wide ? {lt32, gt32, eq32} : {lt16, gt16, eq16};
    used = wide ? used32 : used16;
    @(negedge clk);
    if (wide) rr32 = 1'b1; else rr16 = 1'b1;
    @(posedge clk);
    #1;
    rr32 = 1'b0;
    rr16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({srdy16, rv16, lt16, gt16, eq16, used16} !== 8'b1000_0000)
      $display("FAIL reset16 got %b want 10000000",
               {srdy16, rv16, lt16, gt16, eq16, used16});
    else passed++;
    total++;
    if ({srdy32, rv32, lt32, gt32, eq32, used32} !== 8'b1000_0000)
      $display("FAIL reset32 got %b want 10000000",
               {srdy32, rv32, lt32, gt32, eq32, used32});
    else passed++;
  endtask

  // Directed 16-bit cases: a, b, mode, expected {lt,gt,eq}, expected chunks.
  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h1234, 16'h8000, 16'h8000, 16'h1300, 16'h12F4};
    logic [15:0] tb [5] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h12FF, 16'h12F5};
    bit          tm [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  tf [5] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
    logic [2:0]  tu [5] = '{3'd4, 3'd1, 3'd1, 3'd2, 3'd4};
    int lat;
    logic [2:0] flg, used;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, {16'h0, ta[i]}, {16'h0, tb[i]}, tm[i], lat, flg, used);
      total++;
      if (flg !== tf[i] || used !== tu[i] || lat != int'(tu[i]))
        $display("FAIL directed%0d got flags=%b used=%0d lat=%0d want flags=%b used=%0d lat=%0d",
                 i, flg, used, lat, tf[i], tu[i], tu[i]);
      else passed++;
      total++;
      if (rv16 !== 1'b0 || srdy16 !== 1'b1)
        $display("FAIL directed%0d_take got rv=%b srdy=%b want rv=0 srdy=1", i, rv16, srdy16);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int lat = 0;
    @(negedge clk);
    a16 = 16'h1300; b16 = 16'h12FF; sm16 = 1'b0; sv16 = 1'b1;
    @(posedge clk);
    #1;
    sv16 = 1'b0;
    while (!rv16 && lat < 40) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sv16 = 1'b1; a16 = 16'h0000; b16 = 16'hFFFF;
      @(posedge clk);
      #1;
      sv16 = 1'b0;
      total++;
      if ({rv16, srdy16, lt16, gt16, eq16, used16} !== 8'b1001_0010)
        $display("FAIL hold%0d got %b want 10010010", i,
                 {rv16, srdy16, lt16, gt16, eq16, used16});
      else passed++;
    end
    @(negedge clk);
    rr16 = 1'b1;
    @(posedge clk);
    #1;
    rr16 = 1'b0;
    total++;
    if ({rv16, srdy16, gt16, used16} !== 6'b0_1_1_010)
      $display("FAIL release got rv=%b srdy=%b gt=%b used=%0d want rv=0 srdy=1 gt=1 used=2",
               rv16, srdy16, gt16, used16);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [2:0] flg, used;
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; sm16 = 1'b0; sv16 = 1'b1;
    @(posedge clk);
    #1;
    sv16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++;
    if ({srdy16, rv16, lt16, gt16, eq16, used16} !== 8'b1000_0000)
      $display("FAIL midreset got %b want 10000000", {srdy16, rv16, lt16, gt16, eq16, used16});
    else passed++;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (rv16 !== 1'b0 || srdy16 !== 1'b1)
      $display("FAIL midreset_idle got rv=%b srdy=%b want rv=0 srdy=1", rv16, srdy16);
    else passed++;
    run_op(1'b0, 32'h0001, 32'h0002, 1'b0, lat, flg, used);
    total++;
    if (flg !== 3'b100 || used !== 3'd4 || lat != 4)
      $display("FAIL after_reset got flags=%b used=%0d lat=%0d want flags=100 used=4 lat=4",
               flg, used, lat);
    else passed++;
  endtask

  task automatic test_wide();
    int lat;
    logic [2:0] flg, used;
    run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat, flg, used);
    total++;
    if (flg !== 3'b100 || used !== 3'd1 || lat != 1)
      $display("FAIL wide_neg got flags=%b used=%0d lat=%0d want flags=100 used=1 lat=1",
               flg, used, lat);
    else passed++;
    run_op(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, lat, flg, used);
    total++;
    if (flg !== 3'b001 || used !== 3'd4 || lat != 4)
      $display("FAIL wide_eq got flags=%b used=%0d lat=%0d want flags=001 used=4 lat=4",
               flg, used, lat);
    else passed++;
  endtask

  // Random back-to-back ops; the first differing chunk is chosen at random.
  task automatic test_random(input bit wide, input int n);
    int w = wide ? 32 : 16;
    int c = wide ? 8 : 4;
    int lat, eu;
    logic [31:0] a, b, wmask, cmask;
    bit sm;
    logic [2:0] flg, used, ef;
    wmask = wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    cmask = (32'd1 << c) - 32'd1;
    for (int i = 0; i < n; i++) begin
      int k = $urandom_range(w / c, 0);
      a  = $urandom & wmask;
      b  = a;
      sm = 1'($urandom);
      if (k < w / c) begin
        b = b ^ (((32'($urandom_range(int'(cmask), 1))) & cmask) << (k * c));
        if (k > 0) b = (b & ~((32'd1 << (k * c)) - 32'd1)) | ($urandom & ((32'd1 << (k * c)) - 32'd1));
      end
      ef = flags_of(ref_cmp(a, b, w, sm));
      eu = ref_used(a, b, w, c);
      run_op(wide, a, b, sm, lat, flg, used);
      total++;
      if (flg !== ef || int'(used) != eu || lat != eu)
        $display("FAIL rand%0d_%0d a=%h b=%h sm=%0d got flags=%b used=%0d lat=%0d want flags=%b used=%0d",
                 w, i, a, b, sm, flg, used, lat, ef, eu);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_wide();
    test_random(1'b0, 40);
    test_random(1'b1, 30);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
